// File: rtl/aes_pkg.sv
// Shared AES round types, constants and byte addressing.
// Byte k of a state sits at bits [127-8k -: 8]; row = k mod 4, column = k div 4.
package aes_pkg;

    localparam int AES_NB    = 4;
    localparam int AES_BYTES = 16;

    typedef logic [7:0]   aes_byte_t;
    typedef logic [127:0] aes_state_t;

    function automatic int aes_byte_idx(input int r, input int c);
        return c * AES_NB + r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// FIPS-197 forward S-box, purely combinational.
// The table is packed so that entry x occupies bits [8*(255-x) +: 8].
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777b_f26b6fc5_3001672b_fed7ab76,
        128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
        128'hb7fd9326_363ff7cc_34a5e5f1_71d83115,
        128'h04c723c3_1896059a_071280e2_eb27b275,
        128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84,
        128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
        128'hd0efaafb_434d3385_45f9027f_503c9fa8,
        128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
        128'hcd0c13ec_5f974417_c4a77e3d_645d1973,
        128'h60814fdc_222a9088_46eeb814_de5e0bdb,
        128'he0323a0a_4906245c_c2d3ac62_9195e479,
        128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
        128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a,
        128'h703eb566_4803f60e_613557b9_86c11d9e,
        128'he1f89811_69d98e94_9b1e87e9_ce5528df,
        128'h8ca1890d_bfe64268_41992d0f_b054bb16
    };

    logic [10:0] w_base;

    assign w_base = {~i_byte, 3'b000};
    assign o_byte = SBOX_TABLE[w_base +: 8];

endmodule

// File: rtl/aes_sub_shift.sv
// Iterative SubBytes + ShiftRows: LANES shared S-boxes walk the buffered source
// state over 16/LANES cycles, scattering results to their ShiftRows slot.
//
//   state | meaning
//   IDLE  | waiting for a state, in_ready high
//   SUB   | substituting LANES bytes per cycle, busy high
//   DONE  | result presented, waiting for out_ready
module aes_sub_shift
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int STEPS = AES_BYTES / LANES;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("aes_sub_shift: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SUB,
        ST_DONE
    } sub_state_t;

    sub_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    aes_state_t       r_src;
    aes_state_t       r_dst;
    logic             r_out_valid;
    logic             r_busy;

    aes_byte_t  w_sb_in    [LANES];
    aes_byte_t  w_sb_out   [LANES];
    logic [6:0] w_src_base [LANES];
    logic [6:0] w_dst_base [LANES];
    logic       w_last;
    logic       w_accept;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [3:0] w_k;
        logic [1:0] w_row;
        logic [1:0] w_col_dst;

        assign w_k        = 4'(int'(r_cnt) * LANES + l);
        assign w_row      = w_k[1:0];
        // 2-bit subtraction wraps, giving (c - r) mod 4 directly
        assign w_col_dst  = w_k[3:2] - w_row;
        assign w_src_base[l] = {~w_k, 3'b000};
        assign w_dst_base[l] = {~4'(aes_byte_idx(int'(w_row), int'(w_col_dst))), 3'b000};
        assign w_sb_in[l] = r_src[w_src_base[l] +: 8];

        aes_sbox u_sbox (
            .i_byte (w_sb_in[l]),
            .o_byte (w_sb_out[l])
        );
    end

    assign w_last    = (r_cnt == CNT_W'(STEPS - 1));
    assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    assign w_accept  = in_ready && in_valid;
    assign out_valid = r_out_valid;
    assign out_state = r_dst;
    assign busy      = r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_src       <= '0;
            r_dst       <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_src   <= in_state;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SUB;
                    end
                end
                ST_SUB: begin
                    for (int l = 0; l < LANES; l++) begin
                        r_dst[w_dst_base[l] +: 8] <= w_sb_out[l];
                    end
                    if (w_last) begin
                        r_cnt       <= '0;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (in_valid) begin
                            r_src   <= in_state;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= ST_SUB;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cnt       <= '0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_sub_shift.sv
// Scoreboard bench for aes_sub_shift: directed FIPS-197 vectors, backpressure,
// stall patterns, per-LANES latency and a mid-substitution reset.
module tb_aes_sub_shift;

    localparam int L   = 4;
    localparam int LAT = 16 / L + 1;
    localparam int NX  = 4;
    localparam int XL [NX] = '{1, 2, 8, 16};

    localparam logic [127:0] V_ZERO_IN  = 128'h0;
    localparam logic [127:0] V_ZERO_EXP = 128'h63636363636363636363636363636363;
    localparam logic [127:0] V_C1_IN    = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] V_C1_EXP   = 128'h6353e08c0960e104cd70b751bacad0e7;
    localparam logic [127:0] V_B1_IN    = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] V_B1_EXP   = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] V_B2_IN    = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] V_B2_EXP   = 128'h49db873b453953897f02d2f177de961a;
    localparam logic [127:0] V_SEQ_IN   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] V_SEQ_EXP  = 128'h636b6776f201ab7b30d777c5fe7c6f2b;
    localparam logic [127:0] V_FF_IN    = {16{8'hff}};
    localparam logic [127:0] V_FF_EXP   = {16{8'h16}};
    localparam logic [127:0] V_01_IN    = {16{8'h01}};
    localparam logic [127:0] V_01_EXP   = {16{8'h7c}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] in_state, out_state;

    aes_sub_shift #(.LANES(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    logic         x_rst, x_valid;
    logic [127:0] x_state;
    logic         x_in_ready  [NX];
    logic         x_out_valid [NX];
    logic [127:0] x_out_state [NX];
    logic         x_busy      [NX];

    for (genvar g = 0; g < NX; g++) begin : g_x
        aes_sub_shift #(.LANES(XL[g])) u_x (
            .clk       (clk),
            .rst       (x_rst),
            .in_valid  (x_valid),
            .in_ready  (x_in_ready[g]),
            .in_state  (x_state),
            .out_valid (x_out_valid[g]),
            .out_ready (1'b1),
            .out_state (x_out_state[g]),
            .busy      (x_busy[g])
        );
    end

    typedef struct {
        logic [127:0] exp;
        int           acc;
    } sb_t;

    sb_t sb_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called and returns at posedge+#1; the handshake is sampled at negedge.
    task automatic send(input logic [127:0] s, input logic [127:0] e, output int acc);
        int guard = 0;
        acc      = -1;
        in_valid = 1'b1;
        in_state = s;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check("send_timeout", {127'd0, in_ready}, 128'd1);
        end else begin
            acc = cyc;
            sb_q.push_back('{e, cyc});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb_q.size() != 0 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check("drain_empty", 128'(sb_q.size()), 128'd0);
    endtask

    // Drive one state into every extra instance and check latency and result.
    task automatic x_run(input string name, input logic [127:0] s, input logic [127:0] e);
        int acc;
        bit seen [NX];
        int lat  [NX];
        logic [127:0] got [NX];
        for (int g = 0; g < NX; g++) begin
            seen[g] = 1'b0;
            lat[g]  = -1;
            got[g]  = '0;
        end
        x_valid = 1'b1;
        x_state = s;
        @(negedge clk);
        for (int g = 0; g < NX; g++) check({name, "_x_ready"}, {127'd0, x_in_ready[g]}, 128'd1);
        acc = cyc;
        @(posedge clk); #1;
        x_valid = 1'b0;
        x_state = ~s;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            for (int g = 0; g < NX; g++) begin
                if (x_out_valid[g] && !seen[g]) begin
                    seen[g] = 1'b1;
                    lat[g]  = cyc - acc;
                    got[g]  = x_out_state[g];
                end
            end
        end
        for (int g = 0; g < NX; g++) begin
            check({name, "_x_seen"}, {127'd0, seen[g]}, 128'd1);
            check({name, "_x_latency"}, 128'(lat[g]), 128'(16 / XL[g] + 1));
            check({name, "_x_data"}, got[g], e);
        end
        @(posedge clk); #1;
    endtask

    // Monitor: latency on first presentation, data on retirement, hold stability.
    initial begin : mon
        bit           pending = 1'b0;
        bit           held    = 1'b0;
        logic [127:0] held_val = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pending = 1'b0;
                held    = 1'b0;
            end else begin
                if (held) begin
                    check("hold_valid", {127'd0, out_valid}, 128'd1);
                    check("hold_state", out_state, held_val);
                end
                held = 1'b0;
                if (out_valid) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_output: got %0h expected no output (cycle %0d)", out_state, cyc);
                    end else begin
                        if (!pending) begin
                            pending = 1'b1;
                            check("latency", 128'(cyc - sb_q[0].acc), 128'(LAT));
                        end
                        if (out_ready) begin
                            check("data", out_state, sb_q[0].exp);
                            void'(sb_q.pop_front());
                            pending = 1'b0;
                        end else begin
                            held     = 1'b1;
                            held_val = out_state;
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int acc1, acc2, acc_tmp, guard, cnt_v;
        logic [127:0] s_in  [6];
        logic [127:0] s_exp [6];

        rst = 1'b1; in_valid = 1'b0; in_state = '0; out_ready = 1'b1;
        x_rst = 1'b1; x_valid = 1'b0; x_state = '0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0; x_rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_out_state", out_state, 128'd0);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_in_ready", {127'd0, in_ready}, 128'd1);
        @(posedge clk); #1;

        // All-zero state: result valid for exactly one cycle.
        send(V_ZERO_IN, V_ZERO_EXP, acc1);
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 20) begin @(negedge clk); guard++; end
        check("zero_seen", {127'd0, out_valid}, 128'd1);
        @(negedge clk);
        check("zero_one_cycle", {127'd0, out_valid}, 128'd0);
        @(posedge clk); #1;

        // Back-to-back directed vectors with out_ready high.
        send(V_C1_IN, V_C1_EXP, acc1);
        send(V_B1_IN, V_B1_EXP, acc2);
        check("throughput", 128'(acc2 - acc1), 128'(LAT));
        send(V_B2_IN, V_B2_EXP, acc_tmp);
        send(V_SEQ_IN, V_SEQ_EXP, acc_tmp);
        drain();

        // Backpressure: new input waits while the finished result is held.
        out_ready = 1'b0;
        send(V_C1_IN, V_C1_EXP, acc1);
        in_valid = 1'b1;
        in_state = V_B1_IN;
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 20) begin
            check("bp_sub_in_ready", {127'd0, in_ready}, 128'd0);
            @(negedge clk);
            guard++;
        end
        check("bp_reach_done", {127'd0, out_valid}, 128'd1);
        for (int i = 0; i < 10; i++) begin
            check("bp_in_ready", {127'd0, in_ready}, 128'd0);
            @(posedge clk); #1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_accept_ready", {127'd0, in_ready}, 128'd1);
        sb_q.push_back('{V_B1_EXP, cyc});
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // Downstream stall pattern while several states stream in.
        s_in[0] = V_FF_IN;   s_exp[0] = V_FF_EXP;
        s_in[1] = V_01_IN;   s_exp[1] = V_01_EXP;
        s_in[2] = V_SEQ_IN;  s_exp[2] = V_SEQ_EXP;
        s_in[3] = V_B2_IN;   s_exp[3] = V_B2_EXP;
        s_in[4] = V_C1_IN;   s_exp[4] = V_C1_EXP;
        s_in[5] = V_ZERO_IN; s_exp[5] = V_ZERO_EXP;
        fork
            begin
                for (int i = 0; i < 6; i++) send(s_in[i], s_exp[i], acc_tmp);
            end
            begin
                for (int j = 0; j < 60; j++) begin
                    out_ready = ((j % 3) != 1);
                    @(posedge clk); #1;
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Latency and result across lane counts.
        x_run("c1", V_C1_IN, V_C1_EXP);

        // Reset during SUB with cnt = 2 on the single-lane instance.
        x_valid = 1'b1;
        x_state = V_B2_IN;
        @(negedge clk);
        @(posedge clk); #1;
        x_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        x_rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy_before", {127'd0, x_busy[0]}, 128'd1);
        @(posedge clk); #1;
        x_rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", {127'd0, x_out_valid[0]}, 128'd0);
        check("mid_rst_busy", {127'd0, x_busy[0]}, 128'd0);
        check("mid_rst_in_ready", {127'd0, x_in_ready[0]}, 128'd1);
        cnt_v = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (x_out_valid[0]) cnt_v++;
        end
        check("mid_rst_no_output", 128'(cnt_v), 128'd0);
        @(posedge clk); #1;
        x_run("b1", V_B1_IN, V_B1_EXP);

        repeat (5) begin @(posedge clk); #1; end
        check("final_queue_empty", 128'(sb_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
